hazard_pipe_tracker: RTL

- Producer side of the hazard interface. Generates the opcode_ex/mem/wb and dest_ex/mem/wb history that the hazard detector reads.
- Consumes the detector's stall, plus the branch-resolution flush, and drives the PC and IF/ID enables and the ID/EX bubble.
- Sits between the decode stage and the EX/MEM/WB pipeline registers.
- Also keeps stall performance counters.

---
 rtl/hazard_pipe_tracker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker: producer side of the hazard interface.
// It carries the opcode/dest history through EX/MEM/WB and turns the
// detector's stall and the branch flush into PC, IF/ID and bubble controls.
// It also keeps consecutive and total stall counters.
// Optional macro HAZARD_WATCHDOG_EN adds a sticky wd_timeout output. Once
// set, stall is ignored so the pipeline is forced to make progress.
module hazard_pipe_tracker #(
    parameter int OP_W     = 4,
    parameter int REG_W    = 3,
    parameter int NOP      = 0,
    parameter int ST       = 11,
    parameter int BZ       = 12,
    parameter int CNT_W    = 8,
    parameter int WD_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode_id,
    input  logic [REG_W-1:0] dest_id,
    input  logic             stall,
    input  logic             branch_flush,
    output logic [OP_W-1:0]  opcode_ex,
    output logic [OP_W-1:0]  opcode_mem,
    output logic [OP_W-1:0]  opcode_wb,
    output logic [REG_W-1:0] dest_ex,
    output logic [REG_W-1:0] dest_mem,
    output logic [REG_W-1:0] dest_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             bubble_ex,
    output logic [CNT_W-1:0] stall_run,
    output logic [CNT_W-1:0] stall_total,
    output logic [1:0]       state
`ifdef HAZARD_WATCHDOG_EN
    ,
    output logic             wd_timeout
`endif
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] STALLED = 2'd1;
    localparam logic [1:0] FLUSHED = 2'd2;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [OP_W-1:0]  opcode_ex_q, opcode_ex_d, opcode_mem_q, opcode_mem_d, opcode_wb_q, opcode_wb_d;
    logic [REG_W-1:0] dest_ex_q, dest_ex_d, dest_mem_q, dest_mem_d, dest_wb_q, dest_wb_d;
    logic [CNT_W-1:0] stall_run_q, stall_run_d, stall_total_q, stall_total_d;
    logic [1:0]       state_q, state_d;
    logic [REG_W-1:0] dest_eff;
    logic             wd_active;
    logic             stall_eff;
    logic             inject;
    logic             stall_cycle;

`ifdef HAZARD_WATCHDOG_EN
    logic wd_q, wd_d;

    // The watchdog trips on the edge where the stall run reaches the limit.
    // It then stays set until reset.
    always_comb begin
        wd_d = wd_q | ({{(32-CNT_W){1'b0}}, stall_run_d} >= 32'(WD_LIMIT));
    end

    // Sticky watchdog flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd_q <= 1'b0;
        else      wd_q <= wd_d;
    end

    assign wd_active  = wd_q;
    assign wd_timeout = wd_q;
`else
    // Watchdog compiled out. A negative limit cannot occur, so this is always 0.
    assign wd_active = (WD_LIMIT < 0);
`endif

    // Stores, branches and bubbles write no register. r0 is never a hazard source.
    always_comb begin
        dest_eff = dest_id;
        if (opcode_id == OP_W'(NOP) || opcode_id == OP_W'(ST) || opcode_id == OP_W'(BZ))
            dest_eff = '0;
    end

    assign stall_eff   = stall & ~wd_active;
    assign inject      = stall_eff | branch_flush;
    assign stall_cycle = stall & ~branch_flush;

    // Datapath shift and counter next-state.
    // MEM and WB always advance; only the EX entry is replaced by a bubble.
    always_comb begin
        opcode_wb_d   = opcode_mem_q;
        dest_wb_d     = dest_mem_q;
        opcode_mem_d  = opcode_ex_q;
        dest_mem_d    = dest_ex_q;
        opcode_ex_d   = inject ? OP_W'(NOP) : opcode_id;
        dest_ex_d     = inject ? '0 : dest_eff;
        stall_run_d   = stall_cycle ? sat_inc(stall_run_q) : '0;
        stall_total_d = stall_cycle ? sat_inc(stall_total_q) : stall_total_q;
    end

    // FSM next-state. A flush takes priority over a stall in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = branch_flush ? FLUSHED : (stall_eff ? STALLED : RUN);
            STALLED: state_d = branch_flush ? FLUSHED : (stall_eff ? STALLED : RUN);
            FLUSHED: state_d = branch_flush ? FLUSHED : (stall_eff ? STALLED : RUN);
            default: state_d = RUN;
        endcase
    end

    // State, pipeline history and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_ex_q   <= '0;
            opcode_mem_q  <= '0;
            opcode_wb_q   <= '0;
            dest_ex_q     <= '0;
            dest_mem_q    <= '0;
            dest_wb_q     <= '0;
            stall_run_q   <= '0;
            stall_total_q <= '0;
            state_q       <= RUN;
        end else begin
            opcode_ex_q   <= opcode_ex_d;
            opcode_mem_q  <= opcode_mem_d;
            opcode_wb_q   <= opcode_wb_d;
            dest_ex_q     <= dest_ex_d;
            dest_mem_q    <= dest_mem_d;
            dest_wb_q     <= dest_wb_d;
            stall_run_q   <= stall_run_d;
            stall_total_q <= stall_total_d;
            state_q       <= state_d;
        end
    end

    // FSM-side controls. A flush overrides a stall: the stalled ID instruction
    // is on the wrong path, so fetch moves on to the branch target.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        bubble_ex  = 1'b1;
        if (rst) begin
            pc_en      = ~stall_eff | branch_flush;
            ifid_en    = ~stall_eff | branch_flush;
            ifid_flush = branch_flush;
            bubble_ex  = inject;
        end
    end

    assign opcode_ex   = opcode_ex_q;
    assign opcode_mem  = opcode_mem_q;
    assign opcode_wb   = opcode_wb_q;
    assign dest_ex     = dest_ex_q;
    assign dest_mem    = dest_mem_q;
    assign dest_wb     = dest_wb_q;
    assign stall_run   = stall_run_q;
    assign stall_total = stall_total_q;
    assign state       = state_q;

endmodule
